// File: rtl/mine_row_param.sv
// Parametrised minesweeper row: COLS cells holding mine, revealed and flag state,
// with registered neighbour counts, one-ring-per-cycle flood reveal and flag count.

// One cell's combinational view: neighbour mine count and cascade-reveal request.
module mine_row_cell #(
  parameter int NUM_W = 4
) (
  input  logic [2:0]       i_ma,    // mines above, columns i-1..i+1
  input  logic [1:0]       i_mh,    // mines in this row, columns i-1 and i+1
  input  logic [2:0]       i_mb,    // mines below, columns i-1..i+1
  input  logic [2:0]       i_za,    // zero_open above, columns i-1..i+1
  input  logic [1:0]       i_zh,    // zero_open in this row, columns i-1 and i+1
  input  logic [2:0]       i_zb,    // zero_open below, columns i-1..i+1
  input  logic             i_rev,
  input  logic             i_flag,
  input  logic             i_mine,
  output logic [NUM_W-1:0] o_cnt,
  output logic             o_casc
);
  // Sum of the eight neighbour mine bits.
  always_comb begin
    o_cnt = '0;
    for (int k = 0; k < 3; k++) o_cnt = o_cnt + NUM_W'(i_ma[k]) + NUM_W'(i_mb[k]);
    for (int k = 0; k < 2; k++) o_cnt = o_cnt + NUM_W'(i_mh[k]);
  end

  // A hidden safe unflagged cell opens when any neighbour is an open zero.
  assign o_casc = ~i_rev & ~i_flag & ~i_mine & ((|i_za) | (|i_zh) | (|i_zb));
endmodule

module mine_row_param #(
  parameter int COLS  = 8,
  parameter int NUM_W = 4,
  parameter int POS_W = $clog2(COLS),
  parameter int FCW   = $clog2(COLS+1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_playing,
  input  logic                  i_load_en,
  input  logic [COLS-1:0]       i_init_mines,
  input  logic [COLS-1:0]       i_mines_above,
  input  logic [COLS-1:0]       i_mines_below,
  input  logic [COLS-1:0]       i_zero_above,
  input  logic [COLS-1:0]       i_zero_below,
  input  logic                  i_user_click,
  input  logic                  i_user_flag,
  input  logic [POS_W-1:0]      i_click_position,
  output logic [COLS-1:0]       o_clicked,
  output logic [COLS-1:0]       o_flags,
  output logic [COLS-1:0]       o_mines,
  output logic [COLS-1:0]       o_zero_open,
  output logic [COLS*NUM_W-1:0] o_nums,
  output logic [FCW-1:0]        o_flag_count,
  output logic                  o_busy,
  output logic                  o_row_won,
  output logic                  o_row_lost
);
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_PLAY, S_LOST} state_t;

  state_t                r_state, w_state_nxt;
  logic [COLS-1:0]       r_mine, r_rev, r_flag;
  logic [COLS*NUM_W-1:0] r_nums;
  logic [FCW-1:0]        r_fcnt;
  logic                  r_lost;

  // Edge columns -1 and COLS are padded with 0 so every cell sees three columns.
  logic [COLS+1:0]       w_ma_pad, w_mh_pad, w_mb_pad, w_za_pad, w_zh_pad, w_zb_pad;
  logic [COLS-1:0]       w_zero, w_casc_raw, w_casc, w_sel, w_click_vec, w_flag_vec;
  logic [COLS-1:0]       w_rev_nxt, w_flag_nxt;
  logic [COLS*NUM_W-1:0] w_cnt;
  logic [FCW-1:0]        w_fcnt_nxt;
  logic                  w_pos_ok, w_act, w_hit_mine;

  assign w_ma_pad = {1'b0, i_mines_above, 1'b0};
  assign w_mh_pad = {1'b0, r_mine,        1'b0};
  assign w_mb_pad = {1'b0, i_mines_below, 1'b0};
  assign w_za_pad = {1'b0, i_zero_above,  1'b0};
  assign w_zh_pad = {1'b0, w_zero,        1'b0};
  assign w_zb_pad = {1'b0, i_zero_below,  1'b0};

  for (genvar g = 0; g < COLS; g++) begin : g_cell
    mine_row_cell #(.NUM_W(NUM_W)) u_cell (
      .i_ma   (w_ma_pad[g +: 3]),
      .i_mh   ({w_mh_pad[g+2], w_mh_pad[g]}),
      .i_mb   (w_mb_pad[g +: 3]),
      .i_za   (w_za_pad[g +: 3]),
      .i_zh   ({w_zh_pad[g+2], w_zh_pad[g]}),
      .i_zb   (w_zb_pad[g +: 3]),
      .i_rev  (r_rev[g]),
      .i_flag (r_flag[g]),
      .i_mine (r_mine[g]),
      .o_cnt  (w_cnt[g*NUM_W +: NUM_W]),
      .o_casc (w_casc_raw[g])
    );
    assign w_zero[g] = r_rev[g] & ~r_mine[g] & (r_nums[g*NUM_W +: NUM_W] == '0);
  end

  // Cascade runs only while playing the row; the playing input does not stop it.
  assign w_casc = (r_state == S_PLAY) ? w_casc_raw : '0;

  // User actions need PLAY, board enable and an in-range column.
  assign w_pos_ok    = ({1'b0, i_click_position} < (POS_W+1)'(COLS));
  assign w_act       = (r_state == S_PLAY) & i_playing & w_pos_ok;
  assign w_sel       = {{(COLS-1){1'b0}}, 1'b1} << i_click_position;
  assign w_click_vec = (w_act & i_user_click) ? (w_sel & ~r_rev & ~r_flag) : '0;
  // Click wins over flag; a cell being opened by the cascade this cycle is not flagged.
  assign w_flag_vec  = (w_act & i_user_flag & ~i_user_click) ? (w_sel & ~r_rev & ~w_casc) : '0;
  assign w_hit_mine  = |(w_click_vec & r_mine);
  assign w_rev_nxt   = r_rev | w_click_vec | w_casc;
  assign w_flag_nxt  = r_flag ^ w_flag_vec;

  // Popcount of the flag vector as it will be after this edge.
  always_comb begin
    w_fcnt_nxt = '0;
    for (int k = 0; k < COLS; k++) w_fcnt_nxt = w_fcnt_nxt + FCW'(w_flag_nxt[k]);
  end

  // Next-state: load restarts from any state; COUNT lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (i_load_en) w_state_nxt = S_COUNT;
    else begin
      case (r_state)
        S_COUNT: w_state_nxt = S_PLAY;
        S_PLAY:  if (w_hit_mine) w_state_nxt = S_LOST;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Cell state: load clears the game, COUNT latches counts, PLAY applies actions and cascade.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mine <= '0;
      r_rev  <= '0;
      r_flag <= '0;
      r_nums <= '0;
      r_fcnt <= '0;
      r_lost <= 1'b0;
    end else if (i_load_en) begin
      r_mine <= i_init_mines;
      r_rev  <= '0;
      r_flag <= '0;
      r_fcnt <= '0;
      r_lost <= 1'b0;
    end else begin
      // Neighbour rows' mine bits only became valid on the load edge, so count here.
      if (r_state == S_COUNT) r_nums <= w_cnt;
      if (r_state == S_PLAY) begin
        r_rev  <= w_rev_nxt;
        r_flag <= w_flag_nxt;
        r_fcnt <= w_fcnt_nxt;
        if (w_hit_mine) r_lost <= 1'b1;
      end
    end
  end

  assign o_clicked    = r_rev;
  assign o_flags      = r_flag;
  assign o_mines      = r_mine;
  assign o_zero_open  = w_zero;
  assign o_nums       = r_nums;
  assign o_flag_count = r_fcnt;
  assign o_busy       = |w_casc;
  assign o_row_won    = (r_state == S_PLAY) & (&(r_rev | r_mine));
  assign o_row_lost   = r_lost;
endmodule

// File: tb/tb_mine_row_param.sv
// Directed bench for mine_row_param: an 8-column row and a 10-column row,
// expected values queued as stimulus is applied and popped when outputs are sampled.
module tb_mine_row_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-column instance
  logic       p8, ld8, uc8, uf8;
  logic [7:0] im8, ma8, mb8, za8, zb8;
  logic [2:0] pos8;
  logic [7:0] clk8, flg8, mn8, zo8;
  logic [31:0] nums8;
  logic [3:0] fc8;
  logic       busy8, won8, lost8;

  // 10-column instance
  logic       p10, ld10, uc10, uf10;
  logic [9:0] im10;
  logic [3:0] pos10;
  logic [9:0] clk10, flg10, mn10, zo10;
  logic [39:0] nums10;
  logic [3:0] fc10;
  logic       busy10, won10, lost10;

  mine_row_param #(.COLS(8)) u8 (
    .i_clk(clk), .i_reset(reset), .i_playing(p8), .i_load_en(ld8), .i_init_mines(im8),
    .i_mines_above(ma8), .i_mines_below(mb8), .i_zero_above(za8), .i_zero_below(zb8),
    .i_user_click(uc8), .i_user_flag(uf8), .i_click_position(pos8),
    .o_clicked(clk8), .o_flags(flg8), .o_mines(mn8), .o_zero_open(zo8), .o_nums(nums8),
    .o_flag_count(fc8), .o_busy(busy8), .o_row_won(won8), .o_row_lost(lost8));

  mine_row_param #(.COLS(10)) u10 (
    .i_clk(clk), .i_reset(reset), .i_playing(p10), .i_load_en(ld10), .i_init_mines(im10),
    .i_mines_above(10'd0), .i_mines_below(10'd0), .i_zero_above(10'd0), .i_zero_below(10'd0),
    .i_user_click(uc10), .i_user_flag(uf10), .i_click_position(pos10),
    .o_clicked(clk10), .o_flags(flg10), .o_mines(mn10), .o_zero_open(zo10), .o_nums(nums10),
    .o_flag_count(fc10), .o_busy(busy10), .o_row_won(won10), .o_row_lost(lost10));

  typedef struct { string tag; logic [63:0] val; } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input string t, input logic [63:0] v);
    exp_t e;
    e.tag = t; e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0h required=queued_entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Reference neighbour counts for an 8-column row.
  function automatic logic [31:0] ref_nums(input logic [7:0] a, input logic [7:0] h,
                                           input logic [7:0] b);
    logic [31:0] r;
    int n, col;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      n = 0;
      for (int d = -1; d <= 1; d++) begin
        col = c + d;
        if (col >= 0 && col < 8) begin
          n += int'(a[col]) + int'(b[col]);
          if (d != 0) n += int'(h[col]);
        end
      end
      r[c*4 +: 4] = 4'(n);
    end
    return r;
  endfunction

  task automatic load8(input logic [7:0] m);
    im8 = m; ld8 = 1'b1; tick(); ld8 = 1'b0; tick();
  endtask

  task automatic load10(input logic [9:0] m);
    im10 = m; ld10 = 1'b1; tick(); ld10 = 1'b0; tick();
  endtask

  initial begin
    reset = 1'b1;
    p8 = 1'b1; ld8 = 0; uc8 = 0; uf8 = 0; im8 = 0; ma8 = 0; mb8 = 0; za8 = 0; zb8 = 0; pos8 = 0;
    p10 = 1'b1; ld10 = 0; uc10 = 0; uf10 = 0; im10 = 0; pos10 = 0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    push("rst_clicked", 0); chk(clk8);
    push("rst_flags", 0);   chk(flg8);
    push("rst_nums", 0);    chk(nums8);
    push("rst_busy_won_lost", 0); chk({busy8, won8, lost8});

    // T1: mine at column 7, counts appear one cycle after load
    im8 = 8'h80; ld8 = 1'b1; tick(); ld8 = 1'b0;
    push("t1_mines", 8'h80); chk(mn8);
    push("t1_nums_in_count", 0); chk(nums8);
    tick();
    push("t1_nums", ref_nums(8'h00, 8'h80, 8'h00)); chk(nums8);

    // Counts with neighbour rows populated
    ma8 = 8'b0000_0101; mb8 = 8'b1000_0000;
    load8(8'b0001_0000);
    push("nums_neigh", ref_nums(8'b0000_0101, 8'b0001_0000, 8'b1000_0000)); chk(nums8);
    ma8 = 0; mb8 = 0;

    // T2: empty row, playing=0 blocks a click, then cascade from col0 with playing dropped
    load8(8'h00);
    p8 = 1'b0; uc8 = 1'b1; pos8 = 3'd3;
    push("t2_click_blocked", 0);
    tick(); chk(clk8);
    p8 = 1'b1; pos8 = 3'd0;
    push("t2_n1_clicked", 8'h01); push("t2_n1_busy", 1); push("t2_n1_won", 0);
    tick(); uc8 = 1'b0; p8 = 1'b0;
    chk(clk8); chk(busy8); chk(won8);
    for (int k = 2; k <= 8; k++) begin
      push($sformatf("t2_n%0d_clicked", k), (64'd1 << k) - 1);
      push($sformatf("t2_n%0d_busy", k), (k < 8) ? 1 : 0);
      tick();
      chk(clk8); chk(busy8);
    end
    push("t2_won", 1); chk(won8);
    p8 = 1'b1;

    // T3: flag, blocked click, unflag, flag on a revealed cell ignored
    load8(8'h00);
    uf8 = 1'b1; pos8 = 3'd3;
    push("t3_flag_set", 8'h08); push("t3_fc1", 1);
    tick(); uf8 = 1'b0; chk(flg8); chk(fc8);
    uc8 = 1'b1;
    push("t3_click_flagged", 0);
    tick(); uc8 = 1'b0; chk(clk8);
    uf8 = 1'b1;
    push("t3_flag_clear", 0); push("t3_fc0", 0);
    tick(); uf8 = 1'b0; chk(flg8); chk(fc8);
    uc8 = 1'b1;
    push("t3_click_col3", 8'h08);
    tick(); uc8 = 1'b0; chk(clk8);
    uf8 = 1'b1;
    push("t3_flag_revealed", 0);
    tick(); uf8 = 1'b0; chk(flg8);

    // Flag on col4 blocks the cascade
    load8(8'h00);
    uf8 = 1'b1; pos8 = 3'd4; tick(); uf8 = 1'b0;
    uc8 = 1'b1; pos8 = 3'd0; tick(); uc8 = 1'b0;
    repeat (5) tick();
    push("blk_clicked", 8'h0F); chk(clk8);
    push("blk_busy", 0); chk(busy8);
    push("blk_fc", 1); chk(fc8);

    // T4: click a mine, row frozen, load clears
    load8(8'h04);
    uc8 = 1'b1; pos8 = 3'd2;
    push("t4_lost", 1); push("t4_clicked", 8'h04);
    tick(); chk(lost8); chk(clk8);
    pos8 = 3'd0;
    push("t4_click_frozen", 8'h04);
    tick(); uc8 = 1'b0; chk(clk8);
    uf8 = 1'b1; pos8 = 3'd5;
    push("t4_flag_frozen", 0); push("t4_lost_sticky", 1);
    tick(); uf8 = 1'b0; chk(flg8); chk(lost8);
    im8 = 8'h00; ld8 = 1'b1;
    push("t4_reload_lost", 0); push("t4_reload_clicked", 0);
    tick(); ld8 = 1'b0; chk(lost8); chk(clk8);

    // T6: reset mid-cascade, then IDLE ignores clicks
    tick();
    uc8 = 1'b1; pos8 = 3'd0; tick(); uc8 = 1'b0;
    tick(); tick();
    push("t6_n3_clicked", 8'h07); chk(clk8);
    reset = 1'b1; tick(); reset = 1'b0;
    push("t6_rst_clicked", 0); chk(clk8);
    push("t6_rst_mines_nums", 0); chk({mn8, nums8});
    push("t6_rst_misc", 0); chk({busy8, won8, lost8, fc8, flg8});
    uc8 = 1'b1;
    push("t6_idle_click", 0);
    tick(); uc8 = 1'b0; chk(clk8);

    // T5: 10-column row, click+flag together, out-of-range position
    load10(10'h000);
    uc10 = 1'b1; uf10 = 1'b1; pos10 = 4'd5;
    push("t5_click_wins", 10'h020); push("t5_flag_dropped", 0);
    tick(); uc10 = 1'b0; uf10 = 1'b0; chk(clk10); chk(flg10);
    load10(10'h000);
    uf10 = 1'b1; pos10 = 4'd10;
    push("t5_oor_flag", 0);
    tick(); chk(flg10);
    uf10 = 1'b0; uc10 = 1'b1;
    push("t5_oor_click", 0);
    tick(); uc10 = 1'b0; chk(clk10);
    uf10 = 1'b1; pos10 = 4'd9;
    push("t5_flag_col9", 10'h200); push("t5_fc", 1);
    tick(); uf10 = 1'b0; chk(flg10); chk(fc10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
